// File: rtl/serial_rx_if.sv
// Serial receiver bus: control/status inputs from the SFR block and received-data outputs.
// The master drives control and RXD and consumes results; the slave is the receiver.
interface serial_rx_if;
    logic       serial_br_i;
    logic       serial_scon7_sm0_i;
    logic       serial_scon5_sm2_i;
    logic       serial_scon4_ren_i;
    logic       serial_scon0_ri_i;
    logic       serial_rxd_i;
    logic [7:0] serial_data_sbuf_o;
    logic       serial_scon2_rb8_o;
    logic       serial_scon0_ri_o;
    logic       serial_load_o;
    logic       serial_shift_clk_o;
    logic       serial_p3en_1_o;
    logic       serial_busy_o;

    modport master (
        output serial_br_i, serial_scon7_sm0_i, serial_scon5_sm2_i, serial_scon4_ren_i,
               serial_scon0_ri_i, serial_rxd_i,
        input  serial_data_sbuf_o, serial_scon2_rb8_o, serial_scon0_ri_o, serial_load_o,
               serial_shift_clk_o, serial_p3en_1_o, serial_busy_o
    );

    modport slave (
        input  serial_br_i, serial_scon7_sm0_i, serial_scon5_sm2_i, serial_scon4_ren_i,
               serial_scon0_ri_i, serial_rxd_i,
        output serial_data_sbuf_o, serial_scon2_rb8_o, serial_scon0_ri_o, serial_load_o,
               serial_shift_clk_o, serial_p3en_1_o, serial_busy_o
    );
endinterface

// File: rtl/serial_rx.sv
// 8051-style serial receiver: mode 0 synchronous shift register and mode 2 9-bit asynchronous frames.
// Build macro SERIAL_RX_MAJORITY_EN selects 2-of-3 majority sampling of each mode 2 bit.
module serial_rx (
    input  logic       serial_clock_i,
    input  logic       serial_reset_i_b,
    serial_rx_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_M0_SHIFT = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_BIT9     = 3'd4,
        ST_STOP     = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       br_prev_r;
    logic       rxd_meta_r;
    logic       rxd_sync_r;
    logic       rxd_prev_r;
    logic [3:0] tick_cnt_r;
    logic [2:0] bit_cnt_r;
    logic       m0_phase_r;
    logic [7:0] shift_r;
    logic       samp8_r;
    logic       bit9_r;
    logic [7:0] sbuf_r;
    logic [7:0] sbuf_s;
    logic       rb8_r;
    logic       rb8_s;
    logic       load_r;
    logic       load_s;
    logic       shift_clk_r;
    logic       shift_clk_s;
    logic       p3en_r;
    logic       p3en_s;
    logic       busy_r;
    logic       busy_s;
    logic       tick_s;
    logic       fall_s;
    logic       abort_s;
    logic       decide_s;
    logic       wrap_s;
    logic       m0_sample_s;
    logic       bit_val_s;
    logic       load_ok_s;

`ifdef SERIAL_RX_MAJORITY_EN
    logic       samp7_r;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign bit_val_s = majority3(samp7_r, samp8_r, rxd_sync_r);
`else
    assign bit_val_s = samp8_r;
`endif

    assign tick_s      = bus.serial_br_i & ~br_prev_r;
    assign fall_s      = rxd_prev_r & ~rxd_sync_r;
    assign decide_s    = tick_s & (tick_cnt_r == 4'd9);
    assign wrap_s      = tick_s & (tick_cnt_r == 4'd15);
    assign m0_sample_s = tick_s & m0_phase_r;
    assign load_ok_s   = ~bus.serial_scon0_ri_i & (~bus.serial_scon5_sm2_i | bit9_r);

    // Baud tick edge register and RXD synchroniser with falling-edge history
    always_ff @(posedge serial_clock_i) begin
        if (!serial_reset_i_b) begin
            br_prev_r  <= 1'b0;
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            br_prev_r  <= bus.serial_br_i;
            rxd_meta_r <= bus.serial_rxd_i;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Abort when the receiver is disabled or the mode changes under an active frame
    always_comb begin
        case (state_r)
            ST_IDLE:     abort_s = 1'b0;
            ST_M0_SHIFT: abort_s = ~bus.serial_scon4_ren_i | bus.serial_scon7_sm0_i;
            default:     abort_s = ~bus.serial_scon4_ren_i | ~bus.serial_scon7_sm0_i;
        endcase
    end

    // State register
    always_ff @(posedge serial_clock_i) begin
        if (!serial_reset_i_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s && !bus.serial_scon7_sm0_i && bus.serial_scon4_ren_i && !bus.serial_scon0_ri_i) begin
                        state_s = ST_M0_SHIFT;
                    end else if (bus.serial_scon7_sm0_i && bus.serial_scon4_ren_i && fall_s) begin
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_M0_SHIFT: begin
                    if (m0_sample_s && (bit_cnt_r == 3'd7)) state_s = ST_IDLE;
                    else                                     state_s = ST_M0_SHIFT;
                end
                ST_START: begin
                    if (decide_s && bit_val_s) state_s = ST_IDLE;
                    else if (wrap_s)           state_s = ST_DATA;
                    else                       state_s = ST_START;
                end
                ST_DATA: begin
                    if (wrap_s && (bit_cnt_r == 3'd7)) state_s = ST_BIT9;
                    else                               state_s = ST_DATA;
                end
                ST_BIT9: begin
                    if (wrap_s) state_s = ST_STOP;
                    else        state_s = ST_BIT9;
                end
                ST_STOP: begin
                    if (decide_s) state_s = ST_IDLE;
                    else          state_s = ST_STOP;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        load_s = 1'b0;
        sbuf_s = sbuf_r;
        rb8_s  = rb8_r;
        if (abort_s) begin
            load_s = 1'b0;
        end else if ((state_r == ST_M0_SHIFT) && m0_sample_s && (bit_cnt_r == 3'd7)) begin
            load_s = 1'b1;
            sbuf_s = {rxd_sync_r, shift_r[7:1]};
        end else if ((state_r == ST_STOP) && decide_s && load_ok_s) begin
            load_s = 1'b1;
            sbuf_s = shift_r;
            rb8_s  = bit9_r;
        end else begin
            load_s = 1'b0;
        end

        if (state_s != ST_M0_SHIFT) begin
            shift_clk_s = 1'b1;
        end else if (tick_s && (state_r == ST_M0_SHIFT)) begin
            shift_clk_s = m0_phase_r;
        end else begin
            shift_clk_s = shift_clk_r;
        end

        p3en_s = (state_s == ST_M0_SHIFT);
        busy_s = (state_s != ST_IDLE);
    end

    // Output registers, counters and the receive shift register
    always_ff @(posedge serial_clock_i) begin
        if (!serial_reset_i_b) begin
            sbuf_r      <= 8'h00;
            rb8_r       <= 1'b0;
            load_r      <= 1'b0;
            shift_clk_r <= 1'b1;
            p3en_r      <= 1'b0;
            busy_r      <= 1'b0;
            tick_cnt_r  <= 4'd0;
            bit_cnt_r   <= 3'd0;
            m0_phase_r  <= 1'b0;
            shift_r     <= 8'h00;
            samp8_r     <= 1'b1;
            bit9_r      <= 1'b0;
`ifdef SERIAL_RX_MAJORITY_EN
            samp7_r     <= 1'b1;
`endif
        end else begin
            sbuf_r      <= sbuf_s;
            rb8_r       <= rb8_s;
            load_r      <= load_s;
            shift_clk_r <= shift_clk_s;
            p3en_r      <= p3en_s;
            busy_r      <= busy_s;
            if (state_r == ST_IDLE) begin
                tick_cnt_r <= 4'd0;
                bit_cnt_r  <= 3'd0;
                m0_phase_r <= 1'b0;
            end else if (state_r == ST_M0_SHIFT) begin
                if (tick_s) begin
                    m0_phase_r <= ~m0_phase_r;
                    if (m0_phase_r) begin
                        shift_r   <= {rxd_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                end
            end else if (tick_s) begin
                tick_cnt_r <= tick_cnt_r + 4'd1;
                if (tick_cnt_r == 4'd8) samp8_r <= rxd_sync_r;
`ifdef SERIAL_RX_MAJORITY_EN
                if (tick_cnt_r == 4'd7) samp7_r <= rxd_sync_r;
`endif
                if (decide_s && (state_r == ST_DATA)) shift_r <= {bit_val_s, shift_r[7:1]};
                if (decide_s && (state_r == ST_BIT9)) bit9_r <= bit_val_s;
                if (wrap_s && (state_r == ST_DATA)) bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    assign bus.serial_data_sbuf_o = sbuf_r;
    assign bus.serial_scon2_rb8_o = rb8_r;
    assign bus.serial_scon0_ri_o  = load_r;
    assign bus.serial_load_o      = load_r;
    assign bus.serial_shift_clk_o = shift_clk_r;
    assign bus.serial_p3en_1_o    = p3en_r;
    assign bus.serial_busy_o      = busy_r;
endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed and randomized mode 2 frames, mode 0 shifts,
// abort and reset cases, compared against a frame-level reference model.
module tb_serial_rx;
    logic       clk = 1'b0;
    logic       rst_b;
    int         n_cmp = 0;
    int         n_err = 0;
    int         load_cnt = 0;
    int         ri_cnt = 0;
    int         fall_cnt = 0;
    logic       sclk_prev = 1'b1;
    logic [7:0] exp_sbuf;
    logic       exp_rb8;

    serial_rx_if bus_if ();

    serial_rx dut (
        .serial_clock_i   (clk),
        .serial_reset_i_b (rst_b),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    // Pulse and shift-clock edge counters, sampled on the falling clock edge
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (bus_if.serial_load_o === 1'b1) load_cnt <= load_cnt + 1;
            if (bus_if.serial_scon0_ri_o === 1'b1) ri_cnt <= ri_cnt + 1;
            if ((sclk_prev === 1'b1) && (bus_if.serial_shift_clk_o === 1'b0)) fall_cnt <= fall_cnt + 1;
        end
        sclk_prev <= bus_if.serial_shift_clk_o;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One baud tick (4 clocks); RXD changes together with the rising baud edge
    task automatic tick_drive(input logic v);
        bus_if.serial_rxd_i = v;
        bus_if.serial_br_i  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_if.serial_br_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Slots: start, d0..d7, bit9, stop; 16 ticks each; optional inversion at tick 8 of d0
    task automatic drive_frame(input logic [7:0] d, input logic b9, input bit glitch, input int n_slots);
        logic [10:0] fr;
        logic        v;
        fr = {1'b1, b9, d, 1'b0};
        for (int s = 0; s < n_slots; s++) begin
            for (int k = 0; k < 16; k++) begin
                v = fr[s];
                if (glitch && (s == 1) && (k == 8)) v = ~v;
                tick_drive(v);
            end
        end
    endtask

    task automatic run_m2(input string tag, input logic [7:0] d, input logic b9,
                          input logic sm2, input logic ri, input bit glitch);
        int         l0;
        int         r0;
        int         exp_loads;
        logic [7:0] dexp;
        bus_if.serial_scon5_sm2_i = sm2;
        bus_if.serial_scon0_ri_i  = ri;
        l0 = load_cnt;
        r0 = ri_cnt;
        drive_frame(d, b9, glitch, 11);
        repeat (4) tick_drive(1'b1);
`ifdef SERIAL_RX_MAJORITY_EN
        dexp = d;
`else
        dexp = glitch ? (d ^ 8'h01) : d;
`endif
        exp_loads = 0;
        if (!ri && (!sm2 || b9)) begin
            exp_loads = 1;
            exp_sbuf  = dexp;
            exp_rb8   = b9;
        end
        check({tag, "_load"}, load_cnt - l0, exp_loads);
        check({tag, "_ri"}, ri_cnt - r0, exp_loads);
        check({tag, "_sbuf"}, {24'h0, bus_if.serial_data_sbuf_o}, {24'h0, exp_sbuf});
        check({tag, "_rb8"}, {31'h0, bus_if.serial_scon2_rb8_o}, {31'h0, exp_rb8});
        check({tag, "_busy"}, {31'h0, bus_if.serial_busy_o}, 32'h0);
        bus_if.serial_scon0_ri_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sbuf"}, {24'h0, bus_if.serial_data_sbuf_o}, 32'h0);
        check({tag, "_rb8"}, {31'h0, bus_if.serial_scon2_rb8_o}, 32'h0);
        check({tag, "_ri"}, {31'h0, bus_if.serial_scon0_ri_o}, 32'h0);
        check({tag, "_load"}, {31'h0, bus_if.serial_load_o}, 32'h0);
        check({tag, "_sclk"}, {31'h0, bus_if.serial_shift_clk_o}, 32'h1);
        check({tag, "_p3en"}, {31'h0, bus_if.serial_p3en_1_o}, 32'h0);
        check({tag, "_busy"}, {31'h0, bus_if.serial_busy_o}, 32'h0);
    endtask

    initial begin
        int         l0;
        int         f0;
        logic [7:0] d;
        logic [7:0] m0_pat [2];

        bus_if.serial_br_i        = 1'b0;
        bus_if.serial_scon7_sm0_i = 1'b1;
        bus_if.serial_scon5_sm2_i = 1'b0;
        bus_if.serial_scon4_ren_i = 1'b0;
        bus_if.serial_scon0_ri_i  = 1'b0;
        bus_if.serial_rxd_i       = 1'b1;
        rst_b = 1'b0;
        exp_sbuf = 8'h00;
        exp_rb8  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_b = 1'b1;
        @(negedge clk);
        bus_if.serial_scon4_ren_i = 1'b1;
        repeat (4) tick_drive(1'b1);

        run_m2("m2_33", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        run_m2("sm2_b9_0", 8'hA2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_m2("sm2_b9_1", 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0);

        l0 = load_cnt;
        repeat (4) tick_drive(1'b0);
        check("false_start_busy", {31'h0, bus_if.serial_busy_o}, 32'h1);
        repeat (20) tick_drive(1'b1);
        check("false_start_idle", {31'h0, bus_if.serial_busy_o}, 32'h0);
        check("false_start_load", load_cnt - l0, 32'h0);
        check("false_start_sbuf", {24'h0, bus_if.serial_data_sbuf_o}, {24'h0, exp_sbuf});

        run_m2("ri_held", 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0);
        run_m2("glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_m2("rand", 8'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'b0);
        end

        // ren dropped during data bit 3
        bus_if.serial_scon5_sm2_i = 1'b0;
        l0 = load_cnt;
        drive_frame(8'hC3, 1'b1, 1'b0, 4);
        repeat (6) tick_drive(1'b0);
        check("abort_pre_busy", {31'h0, bus_if.serial_busy_o}, 32'h1);
        bus_if.serial_scon4_ren_i = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, bus_if.serial_busy_o}, 32'h0);
        check("abort_sclk", {31'h0, bus_if.serial_shift_clk_o}, 32'h1);
        check("abort_p3en", {31'h0, bus_if.serial_p3en_1_o}, 32'h0);
        repeat (20) tick_drive(1'b1);
        check("abort_load", load_cnt - l0, 32'h0);
        check("abort_sbuf", {24'h0, bus_if.serial_data_sbuf_o}, {24'h0, exp_sbuf});
        bus_if.serial_scon4_ren_i = 1'b1;
        repeat (2) tick_drive(1'b1);

        // Reset asserted during data bit 2
        run_m2("pre_rst", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        l0 = load_cnt;
        drive_frame(8'h69, 1'b0, 1'b0, 3);
        repeat (5) tick_drive(1'b0);
        check("rst_pre_busy", {31'h0, bus_if.serial_busy_o}, 32'h1);
        rst_b = 1'b0;
        bus_if.serial_rxd_i = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");
        exp_sbuf = 8'h00;
        exp_rb8  = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (20) tick_drive(1'b1);
        check("rst_after_load", load_cnt - l0, 32'h0);
        check("rst_after_busy", {31'h0, bus_if.serial_busy_o}, 32'h0);

        // Mode 0 receptions
        bus_if.serial_scon4_ren_i = 1'b0;
        @(negedge clk);
        bus_if.serial_scon7_sm0_i = 1'b0;
        bus_if.serial_scon0_ri_i  = 1'b1;
        bus_if.serial_scon4_ren_i = 1'b1;
        tick_drive(1'b1);
        check("m0_ri_blocks", {31'h0, bus_if.serial_busy_o}, 32'h0);
        m0_pat[0] = 8'hA2;
        m0_pat[1] = 8'($urandom);
        for (int p = 0; p < 2; p++) begin
            d  = m0_pat[p];
            l0 = load_cnt;
            f0 = fall_cnt;
            bus_if.serial_scon0_ri_i = 1'b0;
            tick_drive(1'b1);
            for (int b = 0; b < 8; b++) begin
                tick_drive(d[b]);
                if (b == 3) begin
                    check("m0_mid_p3en", {31'h0, bus_if.serial_p3en_1_o}, 32'h1);
                    check("m0_mid_sclk", {31'h0, bus_if.serial_shift_clk_o}, 32'h0);
                end
                tick_drive(d[b]);
            end
            bus_if.serial_scon0_ri_i = 1'b1;
            exp_sbuf = d;
            check("m0_load", load_cnt - l0, 32'h1);
            check("m0_falls", fall_cnt - f0, 32'h8);
            check("m0_sbuf", {24'h0, bus_if.serial_data_sbuf_o}, {24'h0, exp_sbuf});
            check("m0_rb8", {31'h0, bus_if.serial_scon2_rb8_o}, {31'h0, exp_rb8});
            check("m0_end_p3en", {31'h0, bus_if.serial_p3en_1_o}, 32'h0);
            check("m0_end_sclk", {31'h0, bus_if.serial_shift_clk_o}, 32'h1);
            check("m0_end_busy", {31'h0, bus_if.serial_busy_o}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL: serial_clock_i  in  1  system clock; all state changes on the rising edge.
REQ-002 SHALL: serial_reset_i_b  in  1  reset, synchronous and active-low.
REQ-003 SHALL: serial_br_i  in  1  baud sample clock; each 0->1 transition seen between consecutive clock edges is one tick.
REQ-004 SHALL: serial_scon7_sm0_i  in  1  mode select: 0 = mode 0 (synchronous shift register), 1 = mode 2 (9-bit asynchronous).
REQ-005 SHALL: serial_scon5_sm2_i  in  1  multiprocessor enable (mode 2 only).
REQ-006 SHALL: serial_scon4_ren_i  in  1  receive enable.
REQ-007 SHALL: serial_scon0_ri_i  in  1  current RI flag value.
REQ-008 SHALL: serial_rxd_i  in  1  RXD pin data.
REQ-009 SHALL: serial_data_sbuf_o  out  8  received byte, held until the next load.
REQ-010 SHALL: serial_scon2_rb8_o  out  1  received 9th bit (mode 2), held until the next load.
REQ-011 SHALL: serial_scon0_ri_o  out  1  one-cycle pulse that sets RI.
REQ-012 SHALL: serial_load_o  out  1  one-cycle pulse: sbuf/rb8 updated this cycle.
REQ-013 SHALL: serial_shift_clk_o  out  1  mode 0 shift clock driven on TXD, idle high.
REQ-014 SHALL: serial_p3en_1_o  out  1  TXD output enable, 1 only while a mode 0 reception is active.
REQ-015 SHALL: serial_busy_o  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL: serial_rxd_i pass through a 2-flop synchroniser (both flops reset to 1); all logic uses the synchronised value.
REQ-017 SHALL: implement states IDLE, M0_SHIFT, START, DATA, BIT9, STOP.
REQ-018 SHALL: leave IDLE to M0_SHIFT when sm0=0, ren=1 and ri_i=0 on a tick.
REQ-019 SHALL: M0_SHIFT timing: 2 ticks per bit; shift_clk goes low on the first tick and high on the second; RXD is sampled on the high tick; 8 bits LSB first; after bit 7, load and return to IDLE.
REQ-020 SHALL: leave IDLE to START when sm0=1, ren=1 and a synchronised 1->0 RXD transition is detected; the tick counter clears to 0.
REQ-021 SHALL: mode 2 timing: 16 ticks per bit, 4-bit tick counter wrapping 15->0; the bit value is decided at tick 9 (see REQ-032).
REQ-022 SHALL: in START, a decided value of 1 is a false start: return to IDLE with no load.
REQ-023 SHALL: DATA captures 8 bits LSB first using a 3-bit bit counter; BIT9 captures the 9th bit; STOP decides the stop bit and then returns to IDLE.
REQ-024 SHALL: STOP load condition: ri_i=0 AND (sm2=0 OR bit9=1 [bit9=1 sufficient when sm2=1]); the stop bit value is ignored.
REQ-025 SHALL: on load: sbuf and rb8 update, serial_load_o=1 and serial_scon0_ri_o=1 for exactly one clock, one clock after the deciding tick (mode 0 leaves rb8 unchanged).
REQ-026 SHALL: if the load condition is false, discard the frame with no output change.
REQ-027 SHALL: ren=0 or a change of sm0 during any non-IDLE state aborts to IDLE on the next clock: no load, shift_clk=1, p3en_1=0.
REQ-028 SHALL: if ri_i rises mid-frame, the frame is discarded at STOP per REQ-024.
REQ-029 SHALL: a transition back to 0 in IDLE (after STOP) starts a new frame; a line still low after STOP does not start a frame.

Reset
REQ-030 SHALL: while serial_reset_i_b=0 at a clock edge: state=IDLE, counters=0, sbuf=8'h00, rb8=0, ri_o=0, load_o=0, shift_clk=1, p3en_1=0, busy=0, synchroniser=1, tick-edge register=0.
REQ-031 SHALL: reset asserted mid-frame drops the frame with no load pulse.

Configuration
REQ-032 SHALL: with SERIAL_RX_MAJORITY_EN defined, each mode 2 bit is the 2-of-3 majority of samples at ticks 7, 8, 9; without it, the bit is the single sample at tick 8; the decision point stays at tick 9 in both builds.

Verification
REQ-033 SHALL: mode 2, ren=1, sm2=0; frame start,0x33 LSB first,bit9=1,stop -> sbuf=0x33, rb8=1, single RI/load pulse.
REQ-034 SHALL: sm2=1; frame 0xA2 with bit9=0 -> no load; repeated with bit9=1 -> sbuf=0xA2, rb8=1.
REQ-035 SHALL: RXD low for 4 ticks then high -> false start, IDLE, no load; ri_i=1 during a full frame -> no load.
REQ-036 SHALL: mode 0, ren=1, RXD pattern 0xA2 -> 8 low/high shift_clk cycles, p3en_1=1 during the transfer, sbuf=0xA2.
REQ-037 SHALL: ren dropped in DATA bit 3 -> IDLE next clock, no load; reset in DATA -> all REQ-030 values.
REQ-038 SHALL: a 1-tick inverted glitch at tick 8 of data bit 0 -> correct byte with SERIAL_RX_MAJORITY_EN, bit 0 inverted without it.
